// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Circular FIFO of free physical register indices for the rename backend.
//   Rename pops up to ID_WIDTH indices per cycle. Commit pushes stale indices
//   back. A committed-head pointer (chead) lets a branch flush restore every
//   speculatively allocated index in a single cycle.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   alloc_valid  per-lane allocation request from rename
//   alloc_ready  at least ID_WIDTH free indices available (from registered
//                pointers only)
//   free_idx     per-lane granted index, combinational from the current head,
//                compacted in lane order
//   rel_valid    per-lane commit of an instruction that frees a stale index
//   stale_idx    per-lane stale index being returned
//   flush        mispredict recovery: head rewinds to the committed head
// -----------------------------------------------------------------------------
module free_list #(
  parameter int ID_WIDTH  = 2,
  parameter int PRF_DEPTH = 64,
  parameter int ARF_DEPTH = 32,
  parameter int PRF_IDX   = $clog2(PRF_DEPTH),
  parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] alloc_valid,
  output logic                alloc_ready,
  output logic [PRF_IDX-1:0]  free_idx [ID_WIDTH],
  input  logic [ID_WIDTH-1:0] rel_valid,
  input  logic [PRF_IDX-1:0]  stale_idx [ID_WIDTH],
  input  logic                flush
);

  localparam int AW = $clog2(FL_DEPTH);  // entry address width
  localparam int PW = AW + 1;            // pointer width incl. wrap bit

  logic [PRF_IDX-1:0] entry_q [FL_DEPTH];
  logic [PRF_IDX-1:0] entry_d [FL_DEPTH];

  logic [PW-1:0] head_q,  head_d;
  logic [PW-1:0] tail_q,  tail_d;
  logic [PW-1:0] chead_q, chead_d;

  logic [PW-1:0] count;
  logic [PW-1:0] alloc_cnt;
  logic [PW-1:0] rel_cnt;
  logic [PW-1:0] alloc_off [ID_WIDTH];  // valid alloc lanes below lane i
  logic [PW-1:0] rel_off   [ID_WIDTH];  // valid release lanes below lane i
  logic [AW-1:0] rd_addr   [ID_WIDTH];
  logic [AW-1:0] wr_addr   [ID_WIDTH];
  logic          alloc_fire;

  // Occupancy and readiness come only from registered pointers, so
  // alloc_ready never depends on this cycle's requests.
  assign count       = tail_q - head_q;
  assign alloc_ready = (count >= PW'(ID_WIDTH));
  assign alloc_fire  = alloc_ready && !flush;

  // Lane compaction: prefix counts of valid lanes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default infers a latch.
    alloc_cnt = '0;
    rel_cnt   = '0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      alloc_off[i] = alloc_cnt;
      rel_off[i]   = rel_cnt;
      if (alloc_valid[i]) alloc_cnt = alloc_cnt + PW'(1);
      if (rel_valid[i])   rel_cnt   = rel_cnt + PW'(1);
    end
  end

  // Grant reads use the current head; same-cycle releases are not bypassed.
  always_comb begin
    for (int i = 0; i < ID_WIDTH; i++) begin
      rd_addr[i]  = AW'(head_q + alloc_off[i]);
      free_idx[i] = entry_q[rd_addr[i]];
    end
  end

  // Release writes land compacted at tail, tail+1, ...
  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < ID_WIDTH; i++) begin
      wr_addr[i] = AW'(tail_q + rel_off[i]);
      if (rel_valid[i]) entry_d[wr_addr[i]] = stale_idx[i];
    end
  end

  // Pointer update. Each release also retires one allocation, so chead moves
  // with tail. A flush rewinds head to the committed head including this
  // cycle's commits and drops this cycle's allocations.
  always_comb begin
    tail_d  = tail_q + rel_cnt;
    chead_d = chead_q + rel_cnt;
    head_d  = head_q;
    if (flush)           head_d = chead_q + rel_cnt;
    else if (alloc_fire) head_d = head_q + alloc_cnt;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= PW'(FL_DEPTH);  // wrap bit set: list starts full
      // NOTE: the storage array is reset on purpose; the reset image (all
      // non-architectural registers free) is architecturally required, so
      // this memory is built from resettable flops rather than a RAM.
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= PRF_IDX'(ARF_DEPTH + i);
      end
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      entry_q <= entry_d;
    end
  end

`ifndef SYNTHESIS
  // Illegal-use checks, simulation only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (({1'b0, count} + {1'b0, rel_cnt}) <= (PW + 1)'(FL_DEPTH));
      assert (!((|alloc_valid) && !alloc_ready && !flush));
      for (int i = 0; i < ID_WIDTH; i++) begin
        assert (!(rel_valid[i] && (stale_idx[i] == '0)));
      end
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Directed bench for free_list. A queue-based model (free queue plus a
//   queue of speculative allocations) is compared against the DUT on every
//   falling edge; hand-computed literals pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alloc_valid;
  logic       alloc_ready;
  logic [5:0] free_idx [2];
  logic [1:0] rel_valid;
  logic [5:0] stale_idx [2];
  logic       flush;

  always #5 clk = ~clk;

  free_list dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .free_idx    (free_idx),
    .rel_valid   (rel_valid),
    .stale_idx   (stale_idx),
    .flush       (flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: m_free holds free indices in pop order; m_spec holds allocated but
  // uncommitted indices in allocation order.
  // ---------------------------------------------------------------------------
  int m_free[$];
  int m_spec[$];
  bit m_ready;
  int cmp_k;

  always @(posedge clk) begin
    if (rst) begin
      m_free = {};
      m_spec = {};
      for (int i = 0; i < 32; i++) m_free.push_back(32 + i);
    end else begin
      m_ready = (m_free.size() >= 2);
      for (int l = 0; l < 2; l++) begin
        if (rel_valid[l] && m_spec.size() > 0) void'(m_spec.pop_front());
      end
      if (flush) begin
        while (m_spec.size() > 0) m_free.push_front(m_spec.pop_back());
      end else if (m_ready) begin
        for (int l = 0; l < 2; l++) begin
          if (alloc_valid[l] && m_free.size() > 0) m_spec.push_back(m_free.pop_front());
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (rel_valid[l]) m_free.push_back(int'(stale_idx[l]));
      end
    end
  end

  // Compare process: runs every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_alloc_ready", alloc_ready, m_free.size() >= 2);
      if (m_free.size() >= 2) begin
        cmp_k = 0;
        for (int l = 0; l < 2; l++) begin
          if (alloc_valid[l]) begin
            check($sformatf("model_free_idx[%0d]", l), free_idx[l], m_free[cmp_k]);
            cmp_k++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] av, input logic [1:0] rv,
                       input int s0, input int s1, input logic fl);
    alloc_valid  = av;
    rel_valid    = rv;
    stale_idx[0] = 6'(s0);
    stale_idx[1] = 6'(s1);
    flush        = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 1, 1, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] av_tab [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
  logic [1:0] rv_tab [4] = '{2'b11, 2'b10, 2'b01, 2'b11};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] av;
    logic [1:0] rv;

    rst = 1'b1;
    drive(2'b00, 2'b00, 1, 1, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Reset image and first dual allocations.
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    settle();
    check("reset_ready", alloc_ready, 1);
    check("reset_free0", free_idx[0], 32);
    check("reset_free1", free_idx[1], 33);
    tick();
    settle();
    check("second_free0", free_idx[0], 34);
    check("second_free1", free_idx[1], 35);
    tick();

    // Compaction: only lane 1 valid, then only lane 0.
    do_reset();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    tick();
    drive(2'b10, 2'b00, 1, 1, 1'b0);
    settle();
    check("compact_lane1", free_idx[1], 34);
    tick();
    drive(2'b01, 2'b00, 1, 1, 1'b0);
    settle();
    check("compact_lane0", free_idx[0], 35);
    tick();

    // Drain to empty, hold, then release {5,7}.
    do_reset();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    repeat (16) tick();
    drive(2'b00, 2'b00, 1, 1, 1'b0);
    settle();
    check("empty_ready", alloc_ready, 0);
    tick();
    settle();
    check("empty_hold_ready", alloc_ready, 0);
    tick();
    drive(2'b00, 2'b11, 5, 7, 1'b0);
    settle();
    check("release_cycle_ready", alloc_ready, 0);
    tick();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    settle();
    check("refill_ready", alloc_ready, 1);
    check("refill_free0", free_idx[0], 5);
    check("refill_free1", free_idx[1], 7);
    tick();

    // Allocate 32..35, commit two (stale 3,4), flush.
    do_reset();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    repeat (2) tick();
    drive(2'b00, 2'b11, 3, 4, 1'b0);
    tick();
    drive(2'b00, 2'b00, 1, 1, 1'b1);
    tick();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    settle();
    check("flush_ready", alloc_ready, 1);
    check("flush_free0", free_idx[0], 34);
    check("flush_free1", free_idx[1], 35);
    tick();

    // Flush with a one-lane commit (stale 9) and a dropped dual allocation.
    drive(2'b11, 2'b01, 9, 1, 1'b1);
    tick();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    settle();
    check("flush_commit_free0", free_idx[0], 35);
    check("flush_commit_free1", free_idx[1], 36);
    tick();
    repeat (13) tick();  // consumes 37..62
    settle();
    check("wrap_free0", free_idx[0], 63);
    check("wrap_free1", free_idx[1], 3);
    tick();
    settle();
    check("stale_free0", free_idx[0], 4);
    check("stale_free1", free_idx[1], 9);
    tick();
    drive(2'b00, 2'b00, 1, 1, 1'b0);
    settle();
    check("drained_ready", alloc_ready, 0);
    tick();

    // Reset in the middle of activity returns to the reset image.
    drive(2'b00, 2'b11, 10, 11, 1'b0);
    tick();
    rst = 1'b1;
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    check("midreset_ready", alloc_ready, 1);
    check("midreset_free0", free_idx[0], 32);
    check("midreset_free1", free_idx[1], 33);
    tick();

    // Wrap-around: 40 cycles of mixed allocations, releases and flushes.
    do_reset();
    drive(2'b11, 2'b00, 1, 1, 1'b0);
    tick();
    for (int i = 0; i < 40; i++) begin
      av = av_tab[i % 4];
      rv = rv_tab[i % 4];
      if (m_free.size() < 2) av = 2'b00;
      if (m_spec.size() == 0) rv = 2'b00;
      else if (m_spec.size() == 1 && rv == 2'b11) rv = 2'b01;
      drive(av, rv, 1 + (i * 7) % 62, 1 + (i * 11) % 62, (i % 13) == 12);
      tick();
    end
    drive(2'b00, 2'b00, 1, 1, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
